delta_weight_gen: RTL
=====================

DELTA_WEIGHT_GEN -- requirements
Module: delta_weight_gen

Interface
REQ-001 Parameter NWBITS, default 16: delta output width; derivative inputs are NWBITS+1 bits signed.
REQ-002 Parameter NPIXEL, default 784: pixels per update pass.
REQ-003 Parameter NCH, default 4: hidden-neuron channels processed in parallel.
REQ-004 Parameter PIXEL_BITS, default 1: unsigned pixel width (1 = binary pixel).
REQ-005 Parameter LR_SHIFT, default 13: learning-rate scale, divide by 2^LR_SHIFT.
REQ-006 Parameter COUNT_BIT, default 10: pixel counter width; SHALL satisfy 2^COUNT_BIT >= NPIXEL.
REQ-007 clk  input  1  sole clock; all state changes on rising edge.
REQ-008 reset  input  1  synchronous, active-high reset.
REQ-009 start  input  1  single-cycle request to begin a pass.
REQ-010 derivative  input  NCH*(NWBITS+1)  signed per-channel derivatives, channel k at bits [k*(NWBITS+1) +: NWBITS+1]; sampled on accepted start.
REQ-011 pixel  input  PIXEL_BITS  current pixel value.
REQ-012 pixel_valid  input  1  pixel is valid this cycle.
REQ-013 busy  output  1  high in RUN state.
REQ-014 delta_weight  output  NCH*NWBITS  signed per-channel weight deltas, channel k at [k*NWBITS +: NWBITS].
REQ-015 dw_valid  output  1  delta_weight valid this cycle.
REQ-016 dw_index  output  COUNT_BIT  pixel index of current delta_weight.
REQ-017 delta_bias  output  NCH*NWBITS  signed per-channel bias deltas.
REQ-018 bias_valid  output  1  delta_bias valid this cycle.
REQ-019 done  output  1  single-cycle pulse coincident with final dw_valid of a pass.

Function
REQ-020 States SHALL be IDLE and RUN only.
- IDLE -> RUN on start; derivatives latched into internal registers; pixel counter cleared to 0.
- RUN -> IDLE on the cycle the pixel with index NPIXEL-1 is accepted.
REQ-021 start SHALL be ignored while in RUN; latched derivatives stay unchanged.
REQ-022 Pixel accepted only when state is RUN and pixel_valid=1; each acceptance increments counter by 1; pixel_valid=0 stalls the counter with no output.
REQ-023 Pixels presented in the start cycle SHALL NOT be accepted (first acceptance no earlier than cycle after start).
REQ-024 Per channel: product = latched derivative (signed) x pixel (zero-extended unsigned), full precision, NWBITS+PIXEL_BITS+2 bits.
REQ-025 Scaling: product divided by 2^LR_SHIFT rounding toward zero (add 2^LR_SHIFT-1 to negative values before arithmetic right shift).
REQ-026 Scaled result SHALL saturate to [-(2^(NWBITS-1)), 2^(NWBITS-1)-1].
REQ-027 Latency: delta_weight, dw_valid, dw_index registered exactly 1 cycle after pixel acceptance; dw_index equals accepted pixel index.
REQ-028 dw_valid=0 in cycles with no acceptance the previous cycle; delta_weight then SHALL read 0.
REQ-029 done asserts with dw_valid for index NPIXEL-1 and stays low otherwise.
REQ-030 delta_bias = scaled/saturated derivative per REQ-025/026 (pixel treated as 1), registered with bias_valid=1 one cycle after accepted start; 0 and bias_valid=0 otherwise.
REQ-031 start accepted in the cycle done pulses (IDLE reached) SHALL begin a new pass; back-to-back passes lose no output.
REQ-032 PIXEL_BITS=1, LR_SHIFT=13 SHALL reproduce the existing binary-pixel hidden-layer delta behaviour for pixel=0 (delta 0) and pixel=1 (scaled derivative).

Reset
REQ-033 reset=1 at any rising edge, including mid-pass: state IDLE, counter 0, latched derivatives 0, busy/dw_valid/bias_valid/done 0, delta_weight/delta_bias/dw_index 0.
REQ-034 reset SHALL take priority over start and pixel_valid in the same cycle; no output from an aborted pass appears after reset.

Verification
REQ-035 Defaults, derivative ch0=32768, ch1=-32768, start, NPIXEL pixels alternating 1/0 with pixel_valid=1 -> ch0 4/0, ch1 -4/0 alternating, dw_index 0..783, done with index 783, busy low after.
REQ-036 Rounding: derivative -8191 and -8192, pixel=1 -> delta 0 and -1; bias same values, bias_valid one cycle after start.
REQ-037 Saturation: PIXEL_BITS=8, LR_SHIFT=0, derivative 65535, pixel 255 -> 32767; derivative -65536, pixel 255 -> -32768.
REQ-038 Stall: pixel_valid low for 5 cycles mid-pass -> no dw_valid for 5 cycles, dw_index continues without gap, total NPIXEL outputs.
REQ-039 start re-pulsed at index 100 with new derivatives -> ignored, outputs use original derivatives; start in done cycle -> second pass immediate.
REQ-040 reset asserted at index 300 -> all outputs 0 next cycle, IDLE; subsequent start runs full clean pass from index 0.

Source files
------------

// File: rtl/delta_weight_gen.sv
// Weight/bias delta generator: scales latched derivatives by each streamed pixel,
// divides by 2^LR_SHIFT (round toward zero) and saturates to NWBITS.
module delta_weight_gen #(
  parameter int unsigned NWBITS     = 16,
  parameter int unsigned NPIXEL     = 784,
  parameter int unsigned NCH        = 4,
  parameter int unsigned PIXEL_BITS = 1,
  parameter int unsigned LR_SHIFT   = 13,
  parameter int unsigned COUNT_BIT  = 10
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start,
  input  logic [NCH*(NWBITS+1)-1:0]     derivative,
  input  logic [PIXEL_BITS-1:0]         pixel,
  input  logic                          pixel_valid,
  output logic                          busy,
  output logic [NCH*NWBITS-1:0]         delta_weight,
  output logic                          dw_valid,
  output logic [COUNT_BIT-1:0]          dw_index,
  output logic [NCH*NWBITS-1:0]         delta_bias,
  output logic                          bias_valid,
  output logic                          done
);

  localparam int unsigned DW = NWBITS + 1;
  localparam int unsigned PW = NWBITS + PIXEL_BITS + 2;

  localparam logic signed [PW-1:0] Rnd    = PW'((1 << LR_SHIFT) - 1);
  localparam logic signed [PW-1:0] SatMax = PW'((1 << (NWBITS - 1)) - 1);
  localparam logic signed [PW-1:0] SatMin = ~SatMax;
  localparam logic [COUNT_BIT-1:0] Last   = COUNT_BIT'(NPIXEL - 1);

  typedef enum logic {StIdle, StRun} state_e;

  state_e                    state_q, state_d;
  logic [COUNT_BIT-1:0]      cnt_q, cnt_d;
  logic [NCH*DW-1:0]         deriv_q, deriv_d;
  logic [NCH*NWBITS-1:0]     dw_q, dw_d;
  logic                      dw_valid_q, dw_valid_d;
  logic [COUNT_BIT-1:0]      dw_index_q, dw_index_d;
  logic [NCH*NWBITS-1:0]     bias_q, bias_d;
  logic                      bias_valid_q, bias_valid_d;
  logic                      done_q, done_d;

  // Negative values get 2^LR_SHIFT-1 added so the arithmetic shift truncates toward zero.
  function automatic logic [NWBITS-1:0] scale_sat(input logic signed [PW-1:0] prod);
    logic signed [PW-1:0] adj;
    logic signed [PW-1:0] shr;
    adj = prod[PW-1] ? prod + Rnd : prod;
    shr = adj >>> LR_SHIFT;
    if (shr > SatMax) begin
      scale_sat = SatMax[NWBITS-1:0];
    end else if (shr < SatMin) begin
      scale_sat = SatMin[NWBITS-1:0];
    end else begin
      scale_sat = shr[NWBITS-1:0];
    end
  endfunction

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    deriv_d      = deriv_q;
    dw_d         = '0;
    dw_valid_d   = 1'b0;
    dw_index_d   = '0;
    bias_d       = '0;
    bias_valid_d = 1'b0;
    done_d       = 1'b0;
    case (state_q)
      StIdle: begin
        if (start) begin
          state_d      = StRun;
          cnt_d        = '0;
          deriv_d      = derivative;
          bias_valid_d = 1'b1;
          for (int k = 0; k < int'(NCH); k++) begin
            bias_d[k*NWBITS +: NWBITS] = scale_sat(PW'($signed(derivative[k*DW +: DW])));
          end
        end
      end
      StRun: begin
        if (pixel_valid) begin
          dw_valid_d = 1'b1;
          dw_index_d = cnt_q;
          cnt_d      = cnt_q + COUNT_BIT'(1);
          for (int k = 0; k < int'(NCH); k++) begin
            dw_d[k*NWBITS +: NWBITS] =
                scale_sat(PW'($signed(deriv_q[k*DW +: DW])) * PW'($signed({1'b0, pixel})));
          end
          if (cnt_q == Last) begin
            done_d  = 1'b1;
            state_d = StIdle;
            cnt_d   = '0;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      deriv_q      <= '0;
      dw_q         <= '0;
      dw_valid_q   <= 1'b0;
      dw_index_q   <= '0;
      bias_q       <= '0;
      bias_valid_q <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      deriv_q      <= deriv_d;
      dw_q         <= dw_d;
      dw_valid_q   <= dw_valid_d;
      dw_index_q   <= dw_index_d;
      bias_q       <= bias_d;
      bias_valid_q <= bias_valid_d;
      done_q       <= done_d;
    end
  end

  assign busy         = (state_q == StRun);
  assign delta_weight = dw_q;
  assign dw_valid     = dw_valid_q;
  assign dw_index     = dw_index_q;
  assign delta_bias   = bias_q;
  assign bias_valid   = bias_valid_q;
  assign done         = done_q;

endmodule
